core_fetch_queue: RTL and testbench
===================================

// Module: core_fetch_queue
// PURPOSE
// - Parametrised successor to the single-entry fetch stage: decouples instruction-memory timing from decode.
// - Keeps up to MAX_OUTSTANDING requests in flight and buffers responses in a DEPTH-entry in-order FIFO.
// - Drives {instruction, pc} to the decoder, honouring decoder stall.
// - Handles branch/flush/exception redirects by squashing the FIFO and discarding late responses.
// PARAMETERS
// - DEPTH           4             FIFO entries; power of two, >=2
// - MAX_OUTSTANDING 2             max granted-but-unanswered requests, 1..DEPTH
// - RESET_PC        32'h0000_0000 first fetch address after reset
// - EXC_VECTOR      32'h0000_0010 redirect target on exception_i
// PORTS
// - clk_i                input   1   clock
// - arst_ni              input   1   asynchronous active-low reset
// - inst_req_o           output  1   fetch request
// - inst_grnt_i          input   1   request accepted this cycle
// - inst_addr_o          output  32  fetch address (word aligned)
// - inst_data_i          input   32  returned instruction word
// - inst_valid_i         input   1   inst_data_i valid; responses return in request order
// - flush_i              input   1   squash pipeline; redirect to branch_pc_i
// - stall_i              input   1   decoder not accepting
// - exception_i          input   1   redirect to EXC_VECTOR
// - branch_i             input   1   taken branch; redirect to branch_pc_i
// - branch_pc_i          input   32  redirect target
// - instruction_o        output  32  FIFO head instruction
// - instruction_valid_o  output  1   FIFO head valid
// - program_cnt_o        output  32  PC of instruction_o
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC; FIFO, outstanding and drop counters=0; inst_req_o=0, inst_addr_o=RESET_PC,
//   instruction_o=0, instruction_valid_o=0, program_cnt_o=0.
// - Accept condition: inst_req_o && inst_grnt_i. On accept, {fetch_pc} is pushed to the in-flight PC queue,
//   fetch_pc += 4 (mod 2^32, wraps to 0), outstanding++. inst_addr_o = fetch_pc; it holds stable while req=1 && !grnt.
// - inst_req_o = !redirect && (outstanding < MAX_OUTSTANDING) && (count + outstanding < DEPTH), where
//   redirect = flush_i|branch_i|exception_i. Credits reserve FIFO space, so a response is never dropped for lack of room.
// - Response: inst_valid_i with drop_cnt==0 pushes {inst_data_i, oldest in-flight PC}; outstanding--.
//   With drop_cnt>0: data is discarded; drop_cnt--, outstanding--.
// - Response with no outstanding request: ignored; no state changes.
// - Output: show-ahead. instruction_valid_o = count!=0; instruction_o/program_cnt_o = head entry.
//   Pop when valid && !stall_i. Push and pop in the same cycle leave count unchanged. Push into empty FIFO is visible
//   the next cycle (1-cycle response-to-decode latency).
// - Redirect (registered effect next cycle): FIFO cleared, instruction_valid_o=0; drop_cnt = outstanding minus the
//   response arriving this cycle; fetch_pc = EXC_VECTOR if exception_i, else branch_pc_i & ~32'h3.
//   Priority: exception_i > flush_i = branch_i. No accept is possible in a redirect cycle (req=0).
// - Redirect while drop_cnt>0: drop_cnt takes the total of still-outstanding responses; nothing stale reaches decode.
// - stall_i only blocks pop; fetching continues until credits run out. Redirect overrides stall_i.
// - Reset mid-operation: all state returns to reset values immediately; late responses after reset are ignored
//   (outstanding=0).
// - Counters are clog2(DEPTH)+1 bits wide; count+outstanding never exceeds DEPTH.
// CONFIGURATION
// - CORE_FETCH_QUEUE_PERF_EN defined: adds output perf_starve_o[31:0]. It counts cycles with instruction_valid_o=0
//   && !stall_i && !redirect, saturates at 32'hFFFF_FFFF, and resets to 0.
// - CORE_FETCH_QUEUE_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
// - Reset release, grant every cycle, valid 1 cycle after grant -> addresses 0x0,0x4,0x8...; first
//   instruction_valid_o 2 cycles after the first grant with program_cnt_o=0x0.
// - stall_i=1 for 10 cycles, DEPTH=4 -> exactly 4 accepts, then inst_req_o=0; release -> pops in order,
//   PCs 0x0..0xC, no loss.
// - Branch to 0x100 with 2 requests outstanding -> next 2 responses discarded; next valid output program_cnt_o=0x100.
// - exception_i and branch_i in the same cycle, branch_pc_i=0x200 -> fetch resumes at 0x10.
// - Hold inst_grnt_i=0 for 5 cycles at addr 0x40 -> inst_addr_o holds 0x40 and inst_req_o stays 1; grant ->
//   next address 0x44.
// - fetch_pc=0xFFFF_FFFC accepted -> next inst_addr_o=0x0; with PERF_EN, empty-FIFO cycles increment perf_starve_o.

Source files
------------

// File: rtl/core_fetch_queue.sv
// Instruction fetch queue: up to MAX_OUTSTANDING memory requests in flight, DEPTH-entry in-order FIFO to decode.
// Optional CORE_FETCH_QUEUE_PERF_EN adds perf_starve_o, a saturating count of decode-starved cycles.
`timescale 1ns/1ps

module core_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_0010
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  output logic        inst_req_o,
  input  logic        inst_grnt_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_data_i,
  input  logic        inst_valid_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        exception_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  output logic [31:0] instruction_o,
  output logic        instruction_valid_o,
  output logic [31:0] program_cnt_o
`ifdef CORE_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_starve_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   fetch_pc_q;
  logic          started_q;
  entry_t        fifo_q [DEPTH];
  logic [31:0]   pcq_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] pcq_wr_q, pcq_rd_q;
  logic [CW-1:0] count_q, outst_q, drop_q;

  logic   redirect, accept, resp, push, pop;
  entry_t head;

  assign redirect = flush_i | branch_i | exception_i;

  // started_q keeps the request low for the first cycle out of reset so the port is quiet while in reset.
  assign inst_req_o = started_q && !redirect && (outst_q < MAX_C) && ((count_q + outst_q) < DEPTH_C);
  assign inst_addr_o = fetch_pc_q;

  assign accept = inst_req_o && inst_grnt_i;
  assign resp   = inst_valid_i && (outst_q != '0);
  assign push   = resp && (drop_q == '0) && !redirect;
  assign pop    = (count_q != '0) && !stall_i && !redirect;

  assign head                = fifo_q[rd_ptr_q];
  assign instruction_valid_o = (count_q != '0);
  assign instruction_o       = instruction_valid_o ? head.instr : '0;
  assign program_cnt_o       = instruction_valid_o ? head.pc    : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      fetch_pc_q <= RESET_PC;
      started_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      started_q <= 1'b1;
      outst_q   <= outst_q + CW'(accept) - CW'(resp);
      if (accept) pcq_wr_q <= pcq_wr_q + AW'(1);
      if (resp)   pcq_rd_q <= pcq_rd_q + AW'(1);

      if (redirect) begin
        // Every response still owed after this cycle belongs to the squashed path.
        fetch_pc_q <= exception_i ? EXC_VECTOR : (branch_pc_i & 32'hFFFF_FFFC);
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        drop_q     <= outst_q - CW'(resp);
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (resp && (drop_q != '0)) drop_q <= drop_q - ONE_C;
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; occupancy counters decide validity and outputs are masked when empty.
  always_ff @(posedge clk_i) begin
    if (accept) pcq_q[pcq_wr_q] <= fetch_pc_q;
    if (push)   fifo_q[wr_ptr_q] <= '{instr: inst_data_i, pc: pcq_q[pcq_rd_q]};
  end

`ifdef CORE_FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      perf_starve_o <= '0;
    end else if (!instruction_valid_o && !stall_i && !redirect && (perf_starve_o != 32'hFFFF_FFFF)) begin
      perf_starve_o <= perf_starve_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed bench for core_fetch_queue: planned grants feed a scoreboard that a negedge monitor drains on each pop.
`timescale 1ns/1ps

module tb_core_fetch_queue;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        inst_req_o, inst_grnt_i, inst_valid_i;
  logic [31:0] inst_addr_o, inst_data_i;
  logic        flush_i, stall_i, exception_i, branch_i;
  logic [31:0] branch_pc_i;
  logic [31:0] instruction_o, program_cnt_o;
  logic        instruction_valid_o;
`ifdef CORE_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_starve_o;
`endif

  core_fetch_queue dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .inst_req_o(inst_req_o), .inst_grnt_i(inst_grnt_i), .inst_addr_o(inst_addr_o),
    .inst_data_i(inst_data_i), .inst_valid_i(inst_valid_i),
    .flush_i(flush_i), .stall_i(stall_i), .exception_i(exception_i),
    .branch_i(branch_i), .branch_pc_i(branch_pc_i),
    .instruction_o(instruction_o), .instruction_valid_o(instruction_valid_o),
    .program_cnt_o(program_cnt_o)
`ifdef CORE_FETCH_QUEUE_PERF_EN
    , .perf_starve_o(perf_starve_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit keep; } plan_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  plan_t       plan[$];
  exp_t        exp_q[$];
  logic [31:0] pend[$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, first_acc_cyc = -1, first_valid_cyc = -1;
  bit          resp_en = 1'b1, spur = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: answers each accepted request one cycle later, in order, while resp_en is set.
  always @(posedge clk) begin
    #2;
    if (spur) begin
      inst_valid_i = 1'b1;
      inst_data_i  = 32'hDEAD_BEEF;
    end else if (resp_en && pend.size() != 0) begin
      inst_valid_i = 1'b1;
      inst_data_i  = mem_word(pend.pop_front());
    end else begin
      inst_valid_i = 1'b0;
      inst_data_i  = '0;
    end
  end

  always @(negedge clk) begin
    if (arst_ni) begin
      if (instruction_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instruction_valid_o && !stall_i && !(flush_i | branch_i | exception_i)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pop: got pc %h, expected no output", program_cnt_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc", program_cnt_o, mon_e.pc);
          check("pop_instr", instruction_o, mon_e.instr);
        end
      end
    end
  end

  task automatic plan_add(input logic [31:0] a, input bit keep);
    plan.push_back('{addr: a, keep: keep});
  endtask

  // All tasks start and end at posedge+1.
  task automatic grant_run(input int ncyc, input bit stop_empty, output int nacc);
    plan_t p;
    nacc = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (stop_empty && plan.size() == 0) break;
      inst_grnt_i = 1'b1;
      @(negedge clk);
      if (inst_req_o) begin
        nacc++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        pend.push_back(inst_addr_o);
        if (plan.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_accept: got addr %h, expected no request", inst_addr_o);
        end else begin
          p = plan.pop_front();
          check("accept_addr", inst_addr_o, p.addr);
          if (p.keep) exp_q.push_back('{instr: mem_word(p.addr), pc: p.addr});
        end
      end
      @(posedge clk); #1;
    end
    inst_grnt_i = 1'b0;
  endtask

  task automatic do_reset();
    arst_ni = 1'b0;
    {inst_grnt_i, flush_i, stall_i, exception_i, branch_i} = '0;
    branch_pc_i = '0;
    resp_en = 1'b1;
    spur = 1'b0;
    pend.delete(); exp_q.delete(); plan.delete();
    first_acc_cyc = -1;
    first_valid_cyc = -1;
    @(negedge clk);
    check("rst_req", inst_req_o, 0);
    check("rst_addr", inst_addr_o, 32'h0);
    check("rst_valid", instruction_valid_o, 0);
    check("rst_instr", instruction_o, 0);
    check("rst_pc", program_cnt_o, 0);
    @(posedge clk); #1;
    arst_ni = 1'b1;
  endtask

  task automatic redirect(input bit exc, input bit fl, input bit br, input logic [31:0] tgt);
    exception_i = exc; flush_i = fl; branch_i = br; branch_pc_i = tgt;
    @(negedge clk);
    check("redirect_req", inst_req_o, 0);
    @(posedge clk); #1;
    exception_i = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_idle"}, instruction_valid_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    inst_valid_i = 1'b0;
    inst_data_i  = '0;
    @(posedge clk); #1;

    // Back-to-back grants from reset; first decode output two cycles after first grant.
    do_reset();
    for (int i = 0; i < 6; i++) plan_add(32'(4 * i), 1'b1);
    grant_run(40, 1'b1, n);
    check("t1_accepts", n, 6);
    drain("t1_drain");
    check("t1_latency", first_valid_cyc - first_acc_cyc, 2);

    // Stalled decoder: credits allow exactly DEPTH accepts, then in-order release.
    do_reset();
    stall_i = 1'b1;
    plan_add(32'h0, 1'b1); plan_add(32'h4, 1'b1); plan_add(32'h8, 1'b1); plan_add(32'hC, 1'b1);
    grant_run(10, 1'b0, n);
    check("t2_accepts", n, 4);
    @(negedge clk);
    check("t2_req_blocked", inst_req_o, 0);
    check("t2_head_valid", instruction_valid_o, 1);
    check("t2_head_pc", program_cnt_o, 32'h0);
    @(posedge clk); #1;
    stall_i = 1'b0;
    drain("t2_drain");

    // Branch with two requests in flight: both late responses are discarded.
    do_reset();
    resp_en = 1'b0;
    plan_add(32'h0, 1'b0); plan_add(32'h4, 1'b0);
    grant_run(10, 1'b1, n);
    check("t3_accepts", n, 2);
    @(negedge clk);
    check("t3_credit_block", inst_req_o, 0);
    @(posedge clk); #1;
    redirect(1'b0, 1'b0, 1'b1, 32'h100);
    resp_en = 1'b1;
    plan_add(32'h100, 1'b1); plan_add(32'h104, 1'b1);
    grant_run(30, 1'b1, n);
    drain("t3_drain");

    // Exception beats branch while the FIFO is full; FIFO is squashed.
    do_reset();
    stall_i = 1'b1;
    plan_add(32'h0, 1'b0); plan_add(32'h4, 1'b0); plan_add(32'h8, 1'b0); plan_add(32'hC, 1'b0);
    grant_run(10, 1'b0, n);
    @(negedge clk);
    check("t4_full_valid", instruction_valid_o, 1);
    @(posedge clk); #1;
    redirect(1'b1, 1'b0, 1'b1, 32'h200);
    stall_i = 1'b0;
    @(negedge clk);
    check("t4_squashed", instruction_valid_o, 0);
    check("t4_exc_addr", inst_addr_o, 32'h10);
    @(posedge clk); #1;
    plan_add(32'h10, 1'b1); plan_add(32'h14, 1'b1);
    grant_run(30, 1'b1, n);
    drain("t4_drain");

    // Flush in the same cycle as a response; unaligned target is word-aligned.
    do_reset();
    plan_add(32'h0, 1'b0);
    grant_run(10, 1'b1, n);
    redirect(1'b0, 1'b1, 1'b0, 32'h83);
    plan_add(32'h80, 1'b1); plan_add(32'h84, 1'b1);
    grant_run(30, 1'b1, n);
    drain("t5_drain");

    // Stray response with nothing outstanding, then request held without grant.
    do_reset();
    redirect(1'b0, 1'b0, 1'b1, 32'h40);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("t6_stray_ignored", instruction_valid_o, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_hold_req", inst_req_o, 1);
      check("t6_hold_addr", inst_addr_o, 32'h40);
      @(posedge clk); #1;
    end
    plan_add(32'h40, 1'b1); plan_add(32'h44, 1'b1);
    grant_run(30, 1'b1, n);
    drain("t6_drain");

    // Fetch address wraps past the top of the address space.
    do_reset();
    redirect(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    plan_add(32'hFFFF_FFFC, 1'b1); plan_add(32'h0, 1'b1); plan_add(32'h4, 1'b1);
    grant_run(30, 1'b1, n);
    drain("t7_drain");

`ifdef CORE_FETCH_QUEUE_PERF_EN
    do_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("perf_starve", perf_starve_o, 32'd5);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
